// File: rtl/subshift_stage.sv
// AES SubBytes + ShiftRows round stage: substitutes SBOX_LANES bytes per cycle, then
// presents ShiftRows(SubBytes(state)) on a registered valid/ready output.
module subshift_stage #(
    parameter int unsigned SBOX_LANES = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         busy_o
);

    localparam int unsigned N     = 16 / SBOX_LANES;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SUB, HOLD} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_q, work_d;
    logic [127:0]       out_q, out_d;

    logic [7:0]         bytes_c   [16];
    logic [7:0]         sub_bytes [16];
    logic [3:0]         lane_idx  [SBOX_LANES];
    logic [7:0]         lane_out  [SBOX_LANES];
    logic [127:0]       sub_c;
    logic [127:0]       shift_c;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: a^254 is the field inverse (0 maps to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
                 ^ 8'h63;
    endfunction

    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        assign lane_idx[j] = 4'(32'(cnt_q) * SBOX_LANES + j);
        assign lane_out[j] = sbox(bytes_c[lane_idx[j]]);
    end

    // Byte k = s[k%4][k/4]; ShiftRows output s'[r][c] = s[r][(c+r)%4].
    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign bytes_c[k]               = work_q[127-8*k -: 8];
        assign sub_bytes[k]             = (CNT_W'(k / SBOX_LANES) == cnt_q)
                                          ? lane_out[k % SBOX_LANES] : bytes_c[k];
        assign sub_c[127-8*k -: 8]      = sub_bytes[k];
        assign shift_c[127-8*k -: 8]    = sub_bytes[4*(((k/4) + (k%4)) % 4) + (k%4)];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    // Flush outranks both the input accept and the output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        work_d  = state_i;
                        cnt_d   = '0;
                        state_d = SUB;
                    end
                end
                SUB: begin
                    work_d = sub_c;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        out_d   = shift_c;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == HOLD);
    assign state_o     = out_q;

endmodule

// File: tb/tb_subshift_stage.sv
// Directed bench for subshift_stage: FIPS-197 vectors, lane-count latency variants,
// backpressure, back-to-back streaming, flush and asynchronous reset.
module tb_subshift_stage;

    localparam logic [127:0] B1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] B1_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] B2_IN  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] B2_OUT = 128'h49db873b453953897f02d2f177de961a;
    localparam logic [127:0] Z_OUT  = {16{8'h63}};
    localparam logic [127:0] S_IN   = {16{8'h53}};
    localparam logic [127:0] S_OUT  = {16{8'hed}};

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, out_ready;
    logic [127:0] state_in;
    logic         in_ready4, out_valid4, busy4;
    logic         in_ready1, out_valid1, busy1;
    logic         in_ready16, out_valid16, busy16;
    logic [127:0] state_o4, state_o1, state_o16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    subshift_stage #(.SBOX_LANES(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready4), .state_i(state_in), .out_valid_o(out_valid4),
        .out_ready_i(out_ready), .state_o(state_o4), .busy_o(busy4));

    subshift_stage #(.SBOX_LANES(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready1), .state_i(state_in), .out_valid_o(out_valid1),
        .out_ready_i(out_ready), .state_o(state_o1), .busy_o(busy1));

    subshift_stage #(.SBOX_LANES(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready16), .state_i(state_in), .out_valid_o(out_valid16),
        .out_ready_i(out_ready), .state_o(state_o16), .busy_o(busy16));

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send_block(input logic [127:0] blk);
        int n;
        n = 0;
        while (!in_ready4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 128'(n < 40), 128'd1);
        in_valid = 1'b1;
        state_in = blk;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid4 && lat < 40);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, l1, l4, l16, k, got, seen;
        int acc [3];
        logic [127:0] ins  [3];
        logic [127:0] outs [3];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
        #12;
        check("rst_out_valid", 128'(out_valid4), 128'd0);
        check("rst_in_ready",  128'(in_ready4),  128'd1);
        check("rst_busy",      128'(busy4),      128'd0);
        check("rst_state_o",   state_o4,         128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // App.B round 1 through all three lane widths at once
        send_block(B1_IN);
        check("sub_busy",     128'(busy4),     128'd1);
        check("sub_in_ready", 128'(in_ready4), 128'd0);
        l1 = 0; l4 = 0; l16 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (out_valid16 && l16 == 0) l16 = c;
            if (out_valid4  && l4  == 0) l4  = c;
            if (out_valid1  && l1  == 0) l1  = c;
        end
        check("lat_l16", 128'(l16), 128'd1);
        check("lat_l4",  128'(l4),  128'd4);
        check("lat_l1",  128'(l1),  128'd16);
        check("b1_l4",   state_o4,  B1_OUT);
        check("b1_l1",   state_o1,  B1_OUT);
        check("b1_l16",  state_o16, B1_OUT);

        // Backpressure with a second block waiting
        in_valid = 1'b1;
        state_in = S_IN;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid",    128'(out_valid4), 128'd1);
            check("bp_in_ready", 128'(in_ready4),  128'd0);
            check("bp_state",    state_o4,         B1_OUT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_valid", 128'(out_valid4), 128'd0);
        check("bp_rel_ready", 128'(in_ready4),  128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp2_busy", 128'(busy4), 128'd1);
        wait_out(lat);
        check("bp2_lat",   128'(lat), 128'd4);
        check("bp2_state", state_o4,  S_OUT);
        @(negedge clk);
        check("one_cycle_valid", 128'(out_valid4), 128'd0);

        // All-zero state
        out_ready = 1'b0;
        send_block(128'd0);
        wait_out(lat);
        check("zero_lat",   128'(lat), 128'd4);
        check("zero_state", state_o4,  Z_OUT);
        out_ready = 1'b1;
        @(negedge clk);

        // Back-to-back streaming of three blocks
        ins[0] = B2_IN; ins[1] = S_IN;  ins[2] = B1_IN;
        outs[0] = B2_OUT; outs[1] = S_OUT; outs[2] = B1_OUT;
        k = 0; got = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        for (int c = 0; c < 80 && got < 3; c++) begin
            if (out_valid4) begin
                check($sformatf("b2b_out%0d", got), state_o4, outs[got]);
                got++;
            end
            if (in_ready4 && k < 3) begin
                in_valid = 1'b1;
                state_in = ins[k];
                acc[k] = c;
                k++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_count",   128'(got),           128'd3);
        check("b2b_space01", 128'(acc[1] - acc[0]), 128'd6);
        check("b2b_space12", 128'(acc[2] - acc[1]), 128'd6);

        // Flush in the second SUB cycle
        out_ready = 1'b0;
        send_block(B2_IN);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fsub_valid", 128'(out_valid4), 128'd0);
        check("fsub_ready", 128'(in_ready4),  128'd1);
        check("fsub_busy",  128'(busy4),      128'd0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid4) seen++;
        end
        check("fsub_no_emit", 128'(seen), 128'd0);
        send_block(B1_IN);
        wait_out(lat);
        check("fsub_next_lat",   128'(lat), 128'd4);
        check("fsub_next_state", state_o4,  B1_OUT);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush in HOLD together with out_ready
        send_block(S_IN);
        wait_out(lat);
        check("fhold_lat", 128'(lat), 128'd4);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        check("fhold_valid", 128'(out_valid4), 128'd0);
        check("fhold_ready", 128'(in_ready4),  128'd1);
        check("fhold_keep",  state_o4,         S_OUT);
        send_block(B2_IN);
        wait_out(lat);
        check("fhold_next_lat",   128'(lat), 128'd4);
        check("fhold_next_state", state_o4,  B2_OUT);
        out_ready = 1'b1;
        @(negedge clk);
        check("fhold_next_drop", 128'(out_valid4), 128'd0);
        out_ready = 1'b0;

        // Asynchronous reset between edges mid-SUB
        send_block(B1_IN);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(out_valid4), 128'd0);
        check("arst_state", state_o4,         128'd0);
        check("arst_ready", 128'(in_ready4),  128'd1);
        check("arst_busy",  128'(busy4),      128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(128'd0);
        wait_out(lat);
        check("arst_next_lat",   128'(lat), 128'd4);
        check("arst_next_state", state_o4,  Z_OUT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
